// File: rtl/bcd_display_mux_if.sv
// Digit-load and display-drive signals of the two-digit seven-segment multiplexer.
// The master side feeds BCD digits and a load strobe. The slave side drives the display lines.
interface bcd_display_mux_if;
    logic [3:0] in0;
    logic [3:0] in1;
    logic       load;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_done;
    logic       pending;

    modport master (output in0, in1, load, input  seg, an, frame_done, pending);
    modport slave  (input  in0, in1, load, output seg, an, frame_done, pending);
endinterface

// File: rtl/bcd_display_mux.sv
// Two-digit, time-multiplexed seven-segment driver with frame-synchronous digit transfer.
// Optional build macro LEADING_ZERO_BLANK_EN turns off the tens slot when the tens digit is 0.
module bcd_display_mux #(
    parameter int DIV   = 4,
    parameter int BLANK = 2
) (
    input  logic              clk,
    input  logic              rst,
    bcd_display_mux_if.slave  bus
);
    localparam int MAXL = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW   = $clog2(MAXL) + 1;

    typedef enum logic [1:0] {GAP1, DIG0, GAP0, DIG1} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            boot_q, boot_d;
    logic [3:0]      hold0_q, hold0_d, hold1_q, hold1_d;
    logic [3:0]      disp0_q, disp0_d, disp1_q, disp1_d;
    logic            pending_q, pending_d;
    logic [6:0]      seg_q, seg_d;
    logic [1:0]      an_q, an_d;
    logic            frame_done_q, frame_done_d;
    logic            slot_end, enter_dig0, xfer;

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'd0:    enc = 7'h3F;
            4'd1:    enc = 7'h06;
            4'd2:    enc = 7'h5B;
            4'd3:    enc = 7'h4F;
            4'd4:    enc = 7'h66;
            4'd5:    enc = 7'h6D;
            4'd6:    enc = 7'h7D;
            4'd7:    enc = 7'h07;
            4'd8:    enc = 7'h7F;
            4'd9:    enc = 7'h6F;
            default: enc = 7'h40;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CW'(1);
        boot_d       = 1'b0;
        slot_end     = 1'b0;
        seg_d        = 7'h00;
        an_d         = 2'b00;

        case (state_q)
            GAP1:    slot_end = (cnt_q == CW'(BLANK - 1));
            DIG0:    slot_end = (cnt_q == CW'(DIV - 1));
            GAP0:    slot_end = (cnt_q == CW'(BLANK - 1));
            default: slot_end = (cnt_q == CW'(DIV - 1));
        endcase

        // The reset cycle itself is blank, so the first GAP1 lasts one extra edge.
        if (boot_q) begin
            cnt_d = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            case (state_q)
                GAP1:    state_d = DIG0;
                DIG0:    state_d = GAP0;
                GAP0:    state_d = DIG1;
                default: state_d = GAP1;
            endcase
        end

        enter_dig0 = (state_d == DIG0) && (state_q != DIG0);
        xfer       = enter_dig0 && pending_q;

        // Transfer takes the old hold contents; a same-edge load waits for the next frame.
        disp0_d    = xfer ? hold0_q : disp0_q;
        disp1_d    = xfer ? hold1_q : disp1_q;
        hold0_d    = bus.load ? bus.in0 : hold0_q;
        hold1_d    = bus.load ? bus.in1 : hold1_q;
        pending_d  = bus.load ? 1'b1 : (xfer ? 1'b0 : pending_q);
        frame_done_d = enter_dig0;

        case (state_d)
            DIG0: begin
                an_d  = 2'b01;
                seg_d = enc(disp0_d);
            end
            DIG1: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (disp1_d != 4'd0) begin
                    an_d  = 2'b10;
                    seg_d = enc(disp1_d);
                end
`else
                an_d  = 2'b10;
                seg_d = enc(disp1_d);
`endif
            end
            default: begin
                an_d  = 2'b00;
                seg_d = 7'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= GAP1;
            cnt_q        <= '0;
            boot_q       <= 1'b1;
            hold0_q      <= 4'd0;
            hold1_q      <= 4'd0;
            disp0_q      <= 4'd0;
            disp1_q      <= 4'd0;
            pending_q    <= 1'b0;
            seg_q        <= 7'h00;
            an_q         <= 2'b00;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            boot_q       <= boot_d;
            hold0_q      <= hold0_d;
            hold1_q      <= hold1_d;
            disp0_q      <= disp0_d;
            disp1_q      <= disp1_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pending    = pending_q;
endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux: per-edge vector table, directed corner sequences,
// then randomized loads and resets checked against a frame-phase reference model.
module tb_bcd_display_mux;
    localparam int DIV   = 4;
    localparam int BLANK = 2;
    localparam int P     = 2 * (DIV + BLANK);

    logic clk;
    logic rst;
    bcd_display_mux_if bus ();

    bcd_display_mux #(.DIV(DIV), .BLANK(BLANK)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] enc_t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Reference model: edges since reset -> position within the frame.
    int         n;
    logic [3:0] h0, h1, d0, d1;
    logic       mp;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_fd, e_pd;

    task automatic model_edge(input logic r, input logic l, input logic [3:0] a, input logic [3:0] b);
        int ph;
        if (r) begin
            n = 0; h0 = 0; h1 = 0; d0 = 0; d1 = 0; mp = 0;
            e_seg = 0; e_an = 0; e_fd = 0; e_pd = 0;
            return;
        end
        n++;
        ph = (n - 1) % P;
        if (ph == BLANK && mp) begin
            d0 = h0; d1 = h1; mp = 0;
        end
        if (l) begin
            h0 = a; h1 = b; mp = 1;
        end
        e_fd = (ph == BLANK);
        e_pd = mp;
        e_seg = 7'h00; e_an = 2'b00;
        if (ph >= BLANK && ph < BLANK + DIV) begin
            e_an = 2'b01; e_seg = enc_t[d0];
        end else if (ph >= 2 * BLANK + DIV) begin
            e_an = 2'b10; e_seg = enc_t[d1];
`ifdef LEADING_ZERO_BLANK_EN
            if (d1 == 4'd0) begin
                e_an = 2'b00; e_seg = 7'h00;
            end
`endif
        end
    endtask

    task automatic drive_edge(input logic r, input logic l, input logic [3:0] a, input logic [3:0] b);
        rst = r; bus.load = l; bus.in0 = a; bus.in1 = b;
        @(posedge clk);
        model_edge(r, l, a, b);
        #1;
    endtask

    task automatic chk(input string name, input logic [6:0] s, input logic [1:0] a,
                       input logic fd, input logic pd);
        vectors++;
        if (bus.seg !== s || bus.an !== a || bus.frame_done !== fd || bus.pending !== pd) begin
            miscompares++;
            $display("FAIL %s: got seg=%h an=%b fd=%b pend=%b, want seg=%h an=%b fd=%b pend=%b",
                     name, bus.seg, bus.an, bus.frame_done, bus.pending, s, a, fd, pd);
        end
    endtask

    task automatic step(input string name, input logic r, input logic l,
                        input logic [3:0] a, input logic [3:0] b);
        drive_edge(r, l, a, b);
        chk(name, e_seg, e_an, e_fd, e_pd);
    endtask

    task automatic idle(input string name, input int k);
        for (int i = 0; i < k; i++) step(name, 1'b0, 1'b0, 4'd0, 4'd0);
    endtask

    typedef struct {
        logic       ld;
        logic [3:0] i0, i1;
        logic [6:0] seg;
        logic [1:0] an;
        logic       fd, pd;
    } vec_t;

    vec_t tbl [24];

    task automatic fill(input int lo, input int hi, input logic [6:0] s, input logic [1:0] a, input logic pd);
        for (int e = lo; e <= hi; e++) begin
            tbl[e-1].ld = 1'b0; tbl[e-1].i0 = 4'd0; tbl[e-1].i1 = 4'd0;
            tbl[e-1].seg = s; tbl[e-1].an = a; tbl[e-1].fd = 1'b0; tbl[e-1].pd = pd;
        end
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] TENS0_SEG = 7'h00;
    localparam logic [1:0] TENS0_AN  = 2'b00;
`else
    localparam logic [6:0] TENS0_SEG = 7'h3F;
    localparam logic [1:0] TENS0_AN  = 2'b10;
`endif

    initial begin
        rst = 1'b1; bus.load = 1'b0; bus.in0 = 4'd0; bus.in1 = 4'd0;

        // Edges 1..24 after reset; load 2,7 sampled at edge 5.
        fill(1, 2, 7'h00, 2'b00, 1'b0);
        fill(3, 4, 7'h3F, 2'b01, 1'b0);
        fill(5, 6, 7'h3F, 2'b01, 1'b1);
        fill(7, 8, 7'h00, 2'b00, 1'b1);
        fill(9, 12, TENS0_SEG, TENS0_AN, 1'b1);
        fill(13, 14, 7'h00, 2'b00, 1'b1);
        fill(15, 18, 7'h07, 2'b01, 1'b0);
        fill(19, 20, 7'h00, 2'b00, 1'b0);
        fill(21, 24, 7'h5B, 2'b10, 1'b0);
        tbl[2].fd = 1'b1;
        tbl[14].fd = 1'b1;
        tbl[4].ld = 1'b1; tbl[4].i0 = 4'd7; tbl[4].i1 = 4'd2;

        drive_edge(1'b1, 1'b0, 4'd0, 4'd0);
        drive_edge(1'b1, 1'b0, 4'd0, 4'd0);
        chk("reset", 7'h00, 2'b00, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            drive_edge(1'b0, tbl[i].ld, tbl[i].i0, tbl[i].i1);
            chk($sformatf("table_edge%0d", i + 1), tbl[i].seg, tbl[i].an, tbl[i].fd, tbl[i].pd);
        end

        // Two loads in one frame: the last wins.
        drive_edge(1'b1, 1'b0, 4'd0, 4'd0);
        idle("t3", 4);
        step("t3", 1'b0, 1'b1, 4'd3, 4'd1);
        idle("t3", 2);
        step("t3", 1'b0, 1'b1, 4'd1, 4'd3);
        idle("t3", 6);
        step("t3", 1'b0, 1'b0, 4'd0, 4'd0);
        chk("t3_units", 7'h06, 2'b01, 1'b1, 1'b0);
        idle("t3", 5);
        step("t3", 1'b0, 1'b0, 4'd0, 4'd0);
        chk("t3_tens", 7'h4F, 2'b10, 1'b0, 1'b0);

        // Load on the transfer edge is held over to the next frame.
        drive_edge(1'b1, 1'b0, 4'd0, 4'd0);
        idle("t4", 13);
        step("t4", 1'b0, 1'b1, 4'd9, 4'd0);
        step("t4", 1'b0, 1'b1, 4'd5, 4'd0);
        chk("t4_first", 7'h6F, 2'b01, 1'b1, 1'b1);
        idle("t4", 11);
        step("t4", 1'b0, 1'b0, 4'd0, 4'd0);
        chk("t4_second", 7'h6D, 2'b01, 1'b1, 1'b0);

        // Invalid units digit with a zero tens digit.
        drive_edge(1'b1, 1'b0, 4'd0, 4'd0);
        step("t5", 1'b0, 1'b1, 4'd12, 4'd0);
        idle("t5", 1);
        step("t5", 1'b0, 1'b0, 4'd0, 4'd0);
        chk("t5_dash", 7'h40, 2'b01, 1'b1, 1'b0);
        idle("t5", 5);
        step("t5", 1'b0, 1'b0, 4'd0, 4'd0);
        chk("t5_tens", TENS0_SEG, TENS0_AN, 1'b0, 1'b0);

        // Reset in the middle of a tens slot.
        drive_edge(1'b1, 1'b0, 4'd0, 4'd0);
        idle("t6", 4);
        step("t6", 1'b0, 1'b1, 4'd8, 4'd8);
        idle("t6", 4);
        step("t6", 1'b1, 1'b1, 4'd4, 4'd4);
        chk("t6_reset", 7'h00, 2'b00, 1'b0, 1'b0);
        idle("t6", 2);
        step("t6", 1'b0, 1'b0, 4'd0, 4'd0);
        chk("t6_restart", 7'h3F, 2'b01, 1'b1, 1'b0);
        idle("t6", 3);
        chk("t6_dig0_end", 7'h3F, 2'b01, 1'b0, 1'b0);

        // Randomized loads with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic r, l;
            r = ($urandom_range(0, 79) == 0);
            l = ($urandom_range(0, 5) == 0);
            step("random", r, l, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
- Two-digit, time-multiplexed seven-segment display driver.
- Sits directly downstream of the binary-to-BCD decoder and consumes its tens digit (out1) and units digit (out0).
- Captures new digits on a load strobe into a holding register. The holding register is copied to the display registers only at frame boundaries, so the display never tears.
- Drives segment and digit-enable lines with blanking gaps between digits to prevent ghosting.

Parameters:
- DIV, 4, cycles each digit is lit per frame; must be >= 1.
- BLANK, 2, dead cycles between digit slots; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- in0  input  4  units BCD digit (from decoder out0)
- in1  input  4  tens BCD digit (from decoder out1)
- load  input  1  capture strobe for in0/in1, sampled each rising edge
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered
- an  output  2  digit enables, active-high: an[0]=units, an[1]=tens; registered
- frame_done  output  1  1-cycle pulse marking frame start, registered
- pending  output  1  holding register contains data not yet displayed, registered

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
  - All state and outputs update only on the rising edge of clk.
- Reset:
  - seg=0, an=0, frame_done=0, pending=0.
  - Holding registers and display registers are cleared to 0.
  - FSM goes to GAP1 with slot counter = 0.
  - rst takes priority over load. Reset mid-frame aborts the current slot immediately.
- Cycle numbering: edge n = nth rising edge after rst is sampled low. Output values are stated as seen after that edge.
- FSM states and slot lengths: GAP1 (BLANK) -> DIG0 (DIV) -> GAP0 (BLANK) -> DIG1 (DIV) -> GAP1 -> ...
  - Frame period = 2*(DIV+BLANK) cycles.
  - After reset: blank after edges 1..BLANK; DIG0 after edges BLANK+1..BLANK+DIV; and so on.
- Outputs registered together with the state, computed from the next state:
  - GAP0/GAP1: an=00, seg=0.
  - DIG0: an=01, seg=enc(disp0).
  - DIG1: an=10, seg=enc(disp1).
- Encoding enc, value -> hex:
  - 0->3F, 1->06, 2->5B, 3->4F, 4->66, 5->6D, 6->7D, 7->07, 8->7F, 9->6F.
  - Any value 10..15 -> 40 (dash).
- Load:
  - On an edge with load=1: hold0<=in0, hold1<=in1, pending<=1.
  - Multiple loads within one frame: the last one wins.
- Transfer:
  - On the edge entering DIG0, if pending=1: disp<=hold and pending<=0.
  - Transfer occurs at most once per frame.
- Simultaneous load and transfer on the same edge:
  - Transfer uses the old hold contents.
  - New values go to hold; pending stays 1 and they appear next frame.
- frame_done is 1 exactly after each edge entering DIG0, and 0 otherwise.
- Slot counter: width clog2(max(DIV,BLANK))+1; resets to 0 on every state change; no other wrap behaviour.
- Display registers change only at transfer or reset; in0/in1 are ignored when load=0.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: during DIG1, if disp1==0, an=00 and seg=0 (tens slot fully dark); slot timing is unchanged. Invalid digits still show the dash.
- Undefined: tens digit 0 shows seg=3F with an=10.

Test Plan:
1. Reset with DIV=4, BLANK=2, no load:
   - Blank after edges 1-2.
   - an=01, seg=3F after edges 3-6; blank after 7-8.
   - an=10, seg=3F after 9-12 (LEADING_ZERO_BLANK_EN undefined); blank after 13-14.
   - frame_done=1 only after edges 3 and 15.
2. in1=2, in0=7, load=1 sampled at edge 5:
   - pending=1 after edges 5-14; display unchanged through edge 14.
   - After edge 15: pending=0, an=01 with seg=07 (edges 15-18), then an=10 with seg=5B (edges 21-24).
3. Loads 1,3 at edge 5 and then 3,1 at edge 8:
   - After edge 15 shows units 1 (seg=06) and tens 3 (seg=4F).
   - Digits 1,3 never appear.
4. Load 0,9 at edge 14, then load 0,5 exactly at edge 15:
   - Frame from edge 15 shows units 9 (6F); pending stays 1.
   - Frame from edge 27 shows units 5 (6D).
5. Load in0=C, in1=0 with LEADING_ZERO_BLANK_EN defined:
   - DIG0 slot: seg=40.
   - DIG1 slot: an=00, seg=0.
6. rst asserted at edge 10 (mid-DIG1), released before edge 11:
   - After edge 10: seg=0, an=0, pending=0.
   - Sequence restarts with DIG0 showing 3F after edges 3-6 counted from the release.
